wait_time_calc: RTL and testbench

//  Parametrised, sequential successor to the bank-queue wait-time lookup table.

---
 rtl/sbqm_pkg.sv | 19 +
 rtl/wt_div_core.sv | 82 ++++++++
 rtl/wait_time_calc.sv | 166 ++++++++++++++++
 tb/tb_wait_time_calc.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sbqm_pkg.sv
// Shared types and helpers for the bank-queue wait-time calculator.
//   wt_state_t : control FSM states (IDLE, CALC, DONE)
//   wt_num_w   : numerator width that holds SVC_TIME*(pcount+tcount-1)
//                without overflow for the given port widths.
package sbqm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } wt_state_t;

    function automatic int wt_num_w(input int p_w, input int t_w, input int svc_time);
        int m;
        m = (p_w > t_w) ? p_w : t_w;
        return m + 1 + $clog2(svc_time + 1);
    endfunction

endpackage

// File: rtl/wt_div_core.sv
// Iterative restoring divider, one quotient bit per clock, MSB first.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset, aborts a running division
//   start_i : load num_i/div_i and begin NUM_W iterations
//   num_i   : dividend (NUM_W bits)
//   div_i   : divisor (T_W bits, caller guarantees non-zero)
//   done_o  : high in the cycle whose edge retires the final quotient bit
//   quot_o  : full quotient, valid while done_o is high
module wt_div_core #(
    parameter int NUM_W = 6,
    parameter int T_W   = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [NUM_W-1:0] num_i,
    input  logic [T_W-1:0]   div_i,
    output logic             done_o,
    output logic [NUM_W-1:0] quot_o
);

    localparam int CNT_W = $clog2(NUM_W + 1);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic [T_W-1:0]   rem_q, rem_d;
    logic [T_W-1:0]   div_q, div_d;
    logic [T_W:0]     shift_s;
    logic [T_W:0]     diff_s;
    logic             qbit_s;

    // One restoring step plus load/hold of the iteration state.
    // num_q doubles as dividend shifter and quotient accumulator.
    always_comb begin
        shift_s = {rem_q, num_q[NUM_W-1]};
        diff_s  = shift_s - {1'b0, div_q};
        qbit_s  = (shift_s >= {1'b0, div_q});
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        rem_d   = rem_q;
        div_d   = div_q;
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = CNT_W'(NUM_W);
            num_d  = num_i;
            rem_d  = '0;
            div_d  = div_i;
        end else if (busy_q) begin
            num_d  = {num_q[NUM_W-2:0], qbit_s};
            // A kept remainder is always below the divisor, so T_W bits suffice.
            rem_d  = T_W'(qbit_s ? diff_s : shift_s);
            cnt_d  = cnt_q - CNT_W'(1);
            busy_d = (cnt_q != CNT_W'(1));
        end else begin
            busy_d = 1'b0;
        end
    end

    // Iteration state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            num_q  <= '0;
            rem_q  <= '0;
            div_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            num_q  <= num_d;
            rem_q  <= rem_d;
            div_q  <= div_d;
        end
    end

    assign done_o = busy_q && (cnt_q == CNT_W'(1));
    // Includes the bit being decided this cycle so the caller can register it.
    assign quot_o = {num_q[NUM_W-2:0], qbit_s};

endmodule

// File: rtl/wait_time_calc.sv
// Estimated bank-queue wait: floor(SVC_TIME*(pcount+tcount-1)/tcount),
// saturating to 2**W_W-1, with valid/ready handshakes on both sides.
//   clk_i       : clock, rising edge
//   rst_i       : synchronous active-high reset
//   in_valid_i  : pcount_i/tcount_i valid
//   in_ready_o  : request accepted (IDLE only)
//   pcount_i    : people in queue
//   tcount_i    : active tellers
//   out_valid_o : result valid, held until out_ready_i
//   out_ready_i : consumer accepts result
//   wtime_o     : estimated wait time
//   err_o       : accepted request had tcount==0
//   sat_o       : true quotient exceeded 2**W_W-1
module wait_time_calc
    import sbqm_pkg::*;
#(
    parameter int P_W      = 3,
    parameter int T_W      = 2,
    parameter int SVC_TIME = 3,
    parameter int W_W      = 5
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [P_W-1:0] pcount_i,
    input  logic [T_W-1:0] tcount_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [W_W-1:0] wtime_o,
    output logic           err_o,
    output logic           sat_o
);

    localparam int NUM_W = wt_num_w(P_W, T_W, SVC_TIME);
    localparam int Q_W   = NUM_W + W_W;
    localparam logic [W_W-1:0] W_MAX = '1;

    wt_state_t        state_q, state_d;
    logic [W_W-1:0]   wtime_q, wtime_d;
    logic             err_q, err_d;
    logic             sat_q, sat_d;
    logic             accept_s;
    logic             special_s;
    logic             start_s;
    logic [NUM_W-1:0] sum_s;
    logic [NUM_W-1:0] num_s;
    logic             div_done_s;
    logic [NUM_W-1:0] quot_s;
    logic [Q_W-1:0]   quot_ext_s;
    logic             over_s;

    assign accept_s   = (state_q == IDLE) && in_valid_i;
    assign special_s  = (tcount_i == '0) || (pcount_i == '0);
    assign start_s    = accept_s && !special_s;
    // pcount>=1 whenever the divider is started, so the -1 never wraps.
    assign sum_s      = NUM_W'(pcount_i) + NUM_W'(tcount_i) - NUM_W'(1);
    assign num_s      = sum_s * NUM_W'(SVC_TIME);
    assign quot_ext_s = Q_W'(quot_s);
    assign over_s     = quot_ext_s > Q_W'(W_MAX);

    wt_div_core #(
        .NUM_W (NUM_W),
        .T_W   (T_W)
    ) u_div (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_s),
        .num_i   (num_s),
        .div_i   (tcount_i),
        .done_o  (div_done_s),
        .quot_o  (quot_s)
    );

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; special cases skip the divider entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    state_d = special_s ? DONE : CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (div_done_s) begin
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result next-value; results only change when entering DONE.
    always_comb begin
        wtime_d = wtime_q;
        err_d   = err_q;
        sat_d   = sat_q;
        if (accept_s && (tcount_i == '0)) begin
            wtime_d = W_MAX;
            err_d   = 1'b1;
            sat_d   = 1'b0;
        end else if (accept_s && (pcount_i == '0)) begin
            wtime_d = '0;
            err_d   = 1'b0;
            sat_d   = 1'b0;
        end else if ((state_q == CALC) && div_done_s) begin
            wtime_d = over_s ? W_MAX : quot_ext_s[W_W-1:0];
            err_d   = 1'b0;
            sat_d   = over_s;
        end else begin
            wtime_d = wtime_q;
        end
    end

    // Result registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wtime_q <= '0;
            err_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            wtime_q <= wtime_d;
            err_q   <= err_d;
            sat_q   <= sat_d;
        end
    end

    // FSM output decode.
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state_q)
            IDLE:    in_ready_o  = 1'b1;
            DONE:    out_valid_o = 1'b1;
            default: begin
                in_ready_o  = 1'b0;
                out_valid_o = 1'b0;
            end
        endcase
    end

    assign wtime_o = wtime_q;
    assign err_o   = err_q;
    assign sat_o   = sat_q;

endmodule

// File: tb/tb_wait_time_calc.sv
// Self-checking bench: dut0 uses the default parameters, dut1 uses
// SVC_TIME=10 to reach the saturation path.
module tb_wait_time_calc;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic       err       [2];
    logic       sat       [2];
    logic [2:0] pc        [2];
    logic [1:0] tc        [2];
    logic [4:0] wt        [2];
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    wait_time_calc #(.P_W(3), .T_W(2), .SVC_TIME(3), .W_W(5)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .pcount_i(pc[0]), .tcount_i(tc[0]), .out_valid_o(out_valid[0]),
        .out_ready_i(out_ready[0]), .wtime_o(wt[0]), .err_o(err[0]), .sat_o(sat[0]));

    wait_time_calc #(.P_W(3), .T_W(2), .SVC_TIME(10), .W_W(5)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .pcount_i(pc[1]), .tcount_i(tc[1]), .out_valid_o(out_valid[1]),
        .out_ready_i(out_ready[1]), .wtime_o(wt[1]), .err_o(err[1]), .sat_o(sat[1]));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Expected {err, sat, wtime} straight from the wait-time rules.
    function automatic logic [6:0] ref_model(input int p, input int t, input int svc);
        int q;
        if (t == 0) return {1'b1, 1'b0, 5'd31};
        if (p == 0) return 7'd0;
        q = (svc * (p + t - 1)) / t;
        if (q > 31) return {1'b0, 1'b1, 5'd31};
        return {2'b00, 5'(q)};
    endfunction

    // Present a request and consume the accepting edge (edge 0).
    task automatic send(input int sel, input int p, input int t);
        @(negedge clk);
        in_valid[sel] = 1'b1;
        pc[sel] = 3'(p);
        tc[sel] = 2'(t);
        check_eq("in_ready_idle", 32'(in_ready[sel]), 32'd1);
        @(posedge clk);
        #1;
        in_valid[sel] = 1'b0;
        pc[sel] = 3'($urandom);
        tc[sel] = 2'($urandom);
    endtask

    // Count cycles from cycle 1 until out_valid, then check the result.
    task automatic wait_check(input int sel, input int ew, input int ee, input int es, input int lat);
        int cyc;
        cyc = 1;
        @(negedge clk);
        check_eq("in_ready_busy", 32'(in_ready[sel]), 32'd0);
        while (!out_valid[sel] && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("latency", 32'(cyc), 32'(lat));
        check_eq("wtime", 32'(wt[sel]), 32'(ew));
        check_eq("err", 32'(err[sel]), 32'(ee));
        check_eq("sat", 32'(sat[sel]), 32'(es));
    endtask

    // Stall the consumer for a few cycles, then complete the handshake.
    task automatic ack(input int sel, input int hold, input int ew);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(out_valid[sel]), 32'd1);
            check_eq("hold_wtime", 32'(wt[sel]), 32'(ew));
        end
        @(negedge clk);
        out_ready[sel] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[sel] = 1'b0;
        @(negedge clk);
        check_eq("post_ack_valid", 32'(out_valid[sel]), 32'd0);
        check_eq("post_ack_ready", 32'(in_ready[sel]), 32'd1);
        check_eq("keep_wtime", 32'(wt[sel]), 32'(ew));
    endtask

    task automatic run(input int sel, input int p, input int t,
                       input int ew, input int ee, input int es, input int lat, input int hold);
        send(sel, p, t);
        wait_check(sel, ew, ee, es, lat);
        ack(sel, hold, ew);
    endtask

    task automatic run_model(input int sel, input int p, input int t, input int hold);
        logic [6:0] r;
        int         svc;
        int         lat;
        svc = (sel == 0) ? 3 : 10;
        r   = ref_model(p, t, svc);
        // Default: NUM_W=6 -> 7; SVC_TIME=10: NUM_W=8 -> 9.
        lat = (p == 0 || t == 0) ? 1 : ((sel == 0) ? 7 : 9);
        run(sel, p, t, int'(r[4:0]), int'(r[6]), int'(r[5]), lat, hold);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] r;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b0; pc[i] = 3'd0; tc[i] = 2'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_in_ready", 32'(in_ready[i]), 32'd1);
            check_eq("rst_out_valid", 32'(out_valid[i]), 32'd0);
            check_eq("rst_wtime", 32'(wt[i]), 32'd0);
            check_eq("rst_err", 32'(err[i]), 32'd0);
            check_eq("rst_sat", 32'(sat[i]), 32'd0);
        end

        // Directed cases with hand-computed expectations.
        run(0, 5, 2, 9, 0, 0, 7, 0);
        run(0, 7, 1, 21, 0, 0, 7, 1);
        run(0, 7, 3, 9, 0, 0, 7, 2);
        run(0, 0, 2, 0, 0, 0, 1, 0);
        run(0, 4, 0, 31, 1, 0, 1, 3);
        run(1, 7, 1, 31, 0, 1, 9, 0);

        // Consumer stalled 20 cycles while new requests are offered.
        send(0, 6, 3);
        wait_check(0, 8, 0, 0, 7);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid[0] = 1'($urandom);
            pc[0] = 3'($urandom);
            tc[0] = 2'($urandom);
            check_eq("stall_wtime", 32'(wt[0]), 32'd8);
            check_eq("stall_ready", 32'(in_ready[0]), 32'd0);
            check_eq("stall_valid", 32'(out_valid[0]), 32'd1);
        end
        @(negedge clk);
        in_valid[0] = 1'b1; pc[0] = 3'd3; tc[0] = 2'd2; out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        @(negedge clk);
        check_eq("release_ready", 32'(in_ready[0]), 32'd1);
        check_eq("release_valid", 32'(out_valid[0]), 32'd0);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        wait_check(0, 6, 0, 0, 7);
        ack(0, 0, 6);

        // Reset in cycle 3 of CALC aborts, then a fresh request completes.
        send(0, 5, 2);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_valid", 32'(out_valid[0]), 32'd0);
        check_eq("abort_ready", 32'(in_ready[0]), 32'd1);
        check_eq("abort_wtime", 32'(wt[0]), 32'd0);
        run(0, 5, 2, 9, 0, 0, 7, 0);

        // Exhaustive sweep at defaults with random consumer stalls.
        for (int p = 0; p < 8; p++) begin
            for (int t = 0; t < 4; t++) begin
                run_model(0, p, t, int'($urandom_range(0, 2)));
            end
        end

        // Random requests on both instances.
        for (int i = 0; i < 40; i++) begin
            run_model(i % 2, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)));
        end

        r = ref_model(7, 3, 10);
        run(1, 7, 3, int'(r[4:0]), int'(r[6]), int'(r[5]), 9, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
